tt_sweep_checker: RTL
=====================

Name: tt_sweep_checker

Overview:
- Hardware counterpart to the exhaustive-stimulus benches used for small combinational labs.
- On `start`, drives every input combination onto a combinational DUT (`dut_in` to the I-pins) and samples the DUT's single output each time.
- Builds the captured truth table and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing vector, so a lab circuit can be self-checked on the board without a simulator.

Parameters:
- N_IN, 4, number of DUT inputs; sweep length is 2**N_IN vectors.
- SETTLE, 2, extra cycles each vector is held before sampling; each vector is held SETTLE+1 cycles; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- expected  input  2**N_IN  golden truth table; bit k = required DUT output for input vector k; latched at accepted start.
- dut_in  output  N_IN  vector driven to DUT; bit N_IN-1 is the slowest-toggling input (I0), bit 0 is the fastest (I3).
- dut_out  input  1  DUT output O.
- busy  output  1  high while sweeping.
- done  output  1  level, high in DONE until the next accepted start or reset.
- pass  output  1  valid when done; 1 iff zero mismatches.
- captured  output  2**N_IN  observed truth table; bit k is written when vector k is sampled.
- err_cnt  output  N_IN+1  number of mismatching vectors, 0..2**N_IN.
- first_err  output  N_IN  lowest vector index that mismatched.
- first_err_valid  output  1  at least one mismatch recorded.

Behaviour:
- Reset (async, any state, including mid-sweep):
  - State goes to IDLE.
  - All outputs go to 0: dut_in, busy, done, pass, captured, err_cnt, first_err, first_err_valid.
  - The latched expected table and the counters also clear.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE to RUN, on the edge e0 where start=1:
  - exp_q <= expected.
  - dut_in <= 0; hold counter <= 0.
  - Clear captured, err_cnt, first_err, first_err_valid, pass, done.
  - busy <= 1.
- RUN, counter < SETTLE: counter increments; dut_in holds.
- RUN, counter == SETTLE (the sample edge for vector k = dut_in):
  - captured[k] <= dut_out.
  - If dut_out != exp_q[k], err_cnt increments.
  - If that is the first mismatch, first_err <= k and first_err_valid <= 1.
  - If k < 2**N_IN-1: dut_in <= k+1 and counter <= 0.
  - Otherwise go to DONE.
- Vector k is sampled at edge e0 + (k+1)*(SETTLE+1). The last sample and DONE entry fall on the same edge, e0 + 2**N_IN*(SETTLE+1).
- DONE entry:
  - busy <= 0; done <= 1; dut_in <= 0.
  - pass <= 1 iff the final err_cnt, including a mismatch on the last vector, is 0.
- start while in RUN is ignored: no restart and no effect on results.
- Changes on `expected` after the accepted start have no effect.
- start in DONE restarts exactly as from IDLE; results clear on that same edge.
- dut_out is treated as synchronous to clk; no synchronizer inside.
- err_cnt saturates naturally at 2**N_IN, so there is no wrap-around within N_IN+1 bits.

Test Plan:
- Pass case, SETTLE=2, expected=16'h6996, DUT = 4-input XOR:
  - busy high for 48 cycles.
  - done at edge e0+48, pass=1, captured=16'h6996, err_cnt=0, first_err_valid=0.
- Stuck-at-0 DUT, expected=16'h6996:
  - err_cnt=8, first_err=1, first_err_valid=1, pass=0, captured=16'h0000.
- Last-vector-only fault: DUT = AND but output forced to 0 at vector 15, expected=16'h8000:
  - err_cnt=1, first_err=15, pass=0; done still at e0+48.
- Ignored inputs:
  - start pulsed at cycles 5 and 20 of a sweep, with expected toggled mid-sweep, gives results identical to the clean pass case.
  - done again lands at e0+48.
- Reset mid-sweep at dut_in=7 (rstn low for 1 cycle):
  - All outputs 0 immediately, without waiting for a clock edge.
  - State is IDLE.
  - A subsequent start completes normally.
- SETTLE=0 build, AND DUT, expected=16'h8000:
  - dut_in increments every cycle.
  - done at e0+16, pass=1.
  - A start while in DONE clears results on the same edge and re-runs.

Source files
------------

// File: rtl/tt_sweep_checker_if.sv
// Bus between a sweep checker and its environment (host control plus the lab circuit under test).
// The checker takes the slave modport; the host/lab side takes the master modport.
interface tt_sweep_checker_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   expected;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   captured;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_err;
  logic                   first_err_valid;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, pass, captured, err_cnt, first_err, first_err_valid
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, pass, captured, err_cnt, first_err, first_err_valid
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: walks every input vector of a small combinational
// circuit, captures its output and compares against a golden table latched at start.
module tt_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rstn,
  tt_sweep_checker_if.slave bus
);

  localparam int VECS  = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [VECS-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VECS-1:0]   captured_q, captured_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   first_err_q, first_err_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mismatch;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d           = state_q;
    exp_d             = exp_q;
    dut_in_d          = dut_in_q;
    cnt_d             = cnt_q;
    captured_d        = captured_q;
    err_cnt_d         = err_cnt_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;
    done_d            = done_q;
    busy_d            = busy_q;
    mismatch          = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d           = S_RUN;
          exp_d             = bus.expected;
          dut_in_d          = '0;
          cnt_d             = '0;
          captured_d        = '0;
          err_cnt_d         = '0;
          first_err_d       = '0;
          first_err_valid_d = 1'b0;
          pass_d            = 1'b0;
          done_d            = 1'b0;
          busy_d            = 1'b1;
        end
      end

      S_RUN: begin
        // start is deliberately not looked at here: a running sweep cannot be restarted.
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          captured_d[dut_in_q] = bus.dut_out;
          mismatch             = (bus.dut_out != exp_q[dut_in_q]);
          if (mismatch) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
            if (!first_err_valid_q) begin
              first_err_d       = dut_in_q;
              first_err_valid_d = 1'b1;
            end
          end
          if (dut_in_q != VEC_LAST) begin
            dut_in_d = dut_in_q + VEC_ONE;
            cnt_d    = '0;
          end else begin
            // pass uses err_cnt_d so a mismatch on the final vector is counted.
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            dut_in_d = '0;
            pass_d   = (err_cnt_d == '0);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= S_IDLE;
      exp_q             <= '0;
      dut_in_q          <= '0;
      cnt_q             <= '0;
      captured_q        <= '0;
      err_cnt_q         <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      exp_q             <= exp_d;
      dut_in_q          <= dut_in_d;
      cnt_q             <= cnt_d;
      captured_q        <= captured_d;
      err_cnt_q         <= err_cnt_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
      done_q            <= done_d;
      busy_q            <= busy_d;
    end
  end

  assign bus.dut_in          = dut_in_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.captured        = captured_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err       = first_err_q;
  assign bus.first_err_valid = first_err_valid_q;

endmodule
